// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with WB->ID write bypass, a per-register
// pending scoreboard for the hazard unit, and a side-effect-free debug port.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic [DEPTH-1:0]  pending_d;
  logic              wr_ok;

  // Register 0 is hard-wired to zero when ZERO_REG is set, so its writes are dropped.
  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // Next register contents: only the addressed register changes on a valid write.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Scoreboard next state: flush clears everything, a write retires its producer,
  // and a reserve (newest producer) overrides both for its own register.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else if (wr_en) begin
      pending_d[wr_addr] = 1'b0;
    end
    if (rsv_en) begin
      pending_d[rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      pending_d[0] = 1'b0;
    end
  end

  // State registers; reset drops any write in flight and clears all pending bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pending_q <= pending_d;
    end
  end

  // Combinational read ports; the in-flight write both forwards its data and
  // satisfies a waiting consumer. Bypass is suppressed while reset is held so
  // outputs read zero regardless of the write strobe.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit_zero;
    logic              bypass_hit;

    assign addr       = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit_zero   = (ZERO_REG != 0) && (addr == '0);
    assign bypass_hit = (BYPASS != 0) && wr_en && !reset && (wr_addr == addr);

    assign rd_data[k*DATA_W +: DATA_W] = hit_zero   ? '0      :
                                         bypass_hit ? wr_data :
                                                      regs_q[addr];
    assign rd_busy[k] = pending_q[addr] && !bypass_hit;
  end

  // Debug port reads committed state only, never the bypass path.
  assign dbg_data = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb (3 read ports, zero register, bypass on).
// A behavioural model of registers and pending flags is compared against the DUT
// on every negative clock edge; directed scenarios add literal expectations.
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             rsv_en = 1'b0;
  logic [AW-1:0]    rsv_addr = '0;
  logic             flush = 1'b0;
  logic [AW-1:0]    dbg_addr = '0;
  logic [DW-1:0]    dbg_data;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  logic [DW-1:0] m_regs [32];
  bit            m_pend [32];

  regfile_mp_sb #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR*AW-1:0] pack3(input int a0, input int a1, input int a2);
    logic [AW-1:0] b0, b1, b2;
    b0 = AW'(a0);
    b1 = AW'(a1);
    b2 = AW'(a2);
    return {b2, b1, b0};
  endfunction

  function automatic logic [DW-1:0] port_data(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  // Reference model: architectural state updated from the behavioural rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else if (wr_en) begin
        m_pend[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
    end
  end

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en && !reset) begin
      for (int k = 0; k < NR; k++) begin
        int a;
        logic [DW-1:0] exp_d;
        logic exp_b;
        bit fwd;
        a = int'(rd_addr[k*AW +: AW]);
        fwd = wr_en && (int'(wr_addr) == a);
        if (a == 0) exp_d = '0;
        else if (fwd) exp_d = wr_data;
        else exp_d = m_regs[a];
        exp_b = m_pend[a] && !fwd;
        check($sformatf("model rd_data[%0d]", k), port_data(k), exp_d);
        check($sformatf("model rd_busy[%0d]", k), {31'b0, rd_busy[k]}, {31'b0, exp_b});
      end
      check("model dbg_data", dbg_data, m_regs[dbg_addr]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic apply_stimulus_random();
    wr_en    = ($urandom_range(0, 1) == 1);
    wr_addr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
    wr_data  = $urandom;
    rsv_en   = ($urandom_range(0, 2) == 0);
    rsv_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
    flush    = ($urandom_range(0, 15) == 0);
    rd_addr  = pack3($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 7));
    dbg_addr = AW'($urandom_range(0, 7));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("reset rd_data0", port_data(0), 32'h0);
    check("reset rd_busy", {29'b0, rd_busy}, 32'h0);
    check("reset dbg_data", dbg_data, 32'h0);
    check_en = 1'b1;

    // Scenario 1: write r5 and reserve r6, then reset mid-write.
    step();
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'h1234;
    rsv_en = 1'b1; rsv_addr = 6;
    step();
    apply_idle();
    rd_addr = pack3(5, 6, 0);
    dbg_addr = 5;
    #1;
    check("r5 written", port_data(0), 32'h1234);
    check("r6 busy", {29'b0, rd_busy}, 32'h2);
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'h9999;
    #2 reset = 1'b1;
    #1;
    check("reset mid rd_data0", port_data(0), 32'h0);
    check("reset mid rd_busy", {29'b0, rd_busy}, 32'h0);
    check("reset mid dbg", dbg_data, 32'h0);
    step();
    reset = 1'b0;
    apply_idle();
    #1;
    check("write dropped by reset", port_data(0), 32'h0);

    // Scenario 2: same-cycle bypass of r3.
    step();
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'hDEADBEEF;
    rd_addr = pack3(3, 3, 0);
    #1;
    check("bypass r3", port_data(0), 32'hDEADBEEF);
    step();
    apply_idle();
    #1;
    check("stored r3", port_data(1), 32'hDEADBEEF);

    // Scenario 3: register 0 ignores writes and reserves.
    step();
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    rsv_en = 1'b1; rsv_addr = 0;
    rd_addr = pack3(0, 0, 0);
    #1;
    check("r0 bypass blocked", port_data(2), 32'h0);
    step();
    apply_idle();
    dbg_addr = 0;
    #1;
    check("r0 reads zero", port_data(0), 32'h0);
    check("r0 never busy", {29'b0, rd_busy}, 32'h0);

    // Scenario 4: reserve r7, busy next cycle, write clears busy in the same cycle.
    step();
    rsv_en = 1'b1; rsv_addr = 7;
    step();
    apply_idle();
    rd_addr = pack3(0, 7, 0);
    #1;
    check("r7 busy", {29'b0, rd_busy}, 32'h2);
    step();
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h55;
    #1;
    check("r7 busy dropped", {29'b0, rd_busy}, 32'h0);
    check("r7 bypass data", port_data(1), 32'h55);

    // Scenario 5: reserve wins over same-cycle write; flush keeps its own reserve.
    step();
    apply_idle();
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'hAA;
    rsv_en = 1'b1; rsv_addr = 9;
    step();
    apply_idle();
    rd_addr = pack3(9, 0, 0);
    #1;
    check("r9 data", port_data(0), 32'hAA);
    check("r9 pending", {29'b0, rd_busy}, 32'h1);
    step();
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 4;
    step();
    apply_idle();
    rd_addr = pack3(4, 9, 7);
    #1;
    check("only r4 pending", {29'b0, rd_busy}, 32'h1);

    // Scenario 6: all ports and the debug port read the same register.
    step();
    wr_en = 1'b1; wr_addr = 12; wr_data = 32'h0F0F0F0F;
    step();
    apply_idle();
    rd_addr = pack3(12, 12, 12);
    dbg_addr = 12;
    #1;
    check("r12 port0", port_data(0), 32'h0F0F0F0F);
    check("r12 port1", port_data(1), 32'h0F0F0F0F);
    check("r12 port2", port_data(2), 32'h0F0F0F0F);
    check("r12 dbg", dbg_data, 32'h0F0F0F0F);

    // Randomized traffic checked by the model.
    for (int n = 0; n < 500; n++) begin
      step();
      apply_stimulus_random();
    end
    step();
    apply_idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
